// File: rtl/vga_pkg.sv
// Shared VGA adapter constants and the pixel record used by the drawing blocks.
package vga_pkg;

    localparam int VGA_X_W      = 8;
    localparam int VGA_Y_W      = 7;
    localparam int VGA_COLOUR_W = 3;
    localparam int VGA_SCREEN_W = 160;
    localparam int VGA_SCREEN_H = 120;

    typedef struct packed {
        logic [VGA_X_W-1:0]      x;
        logic [VGA_Y_W-1:0]      y;
        logic [VGA_COLOUR_W-1:0] colour;
    } pixel_t;

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Requester-side bundle of the plot arbiter: NUM_REQ pixel sources, flattened per field.
interface vga_plot_arbiter_if
    import vga_pkg::*;
#(
    parameter int NUM_REQ = 2
);

    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_lock;
    logic [VGA_X_W*NUM_REQ-1:0]      req_x;
    logic [VGA_Y_W*NUM_REQ-1:0]      req_y;
    logic [VGA_COLOUR_W*NUM_REQ-1:0] req_colour;
    logic [NUM_REQ-1:0]              req_ready;

    // Pixel sources drive the request fields and watch ready.
    modport master (
        output req_valid, req_lock, req_x, req_y, req_colour,
        input  req_ready
    );

    // The arbiter consumes requests and returns the one-hot ready.
    modport slave (
        input  req_valid, req_lock, req_x, req_y, req_colour,
        output req_ready
    );

endinterface

// File: rtl/vga_plot_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request at or above ptr, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       any,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int ID_W = $clog2(NUM_REQ);

    // Each requester gets a distance from ptr; the closest valid one wins.
    always_comb begin
        int best;
        int rank;
        // NOTE: every output gets a default before the loop so no path leaves a latch behind.
        any  = 1'b0;
        idx  = '0;
        best = NUM_REQ;
        rank = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rank = (i + NUM_REQ - int'(ptr)) % NUM_REQ;
            if (req[i] && (rank < best)) begin
                best = rank;
                idx  = ID_W'(i);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the VGA adapter pixel port with burst lock, clipping and drop counter.
module vga_plot_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int X_MAX   = VGA_SCREEN_W,
    parameter int Y_MAX   = VGA_SCREEN_H
) (
    input  logic                       clk,
    input  logic                       rstn,
    vga_plot_arbiter_if.slave          req,
    output logic [VGA_X_W-1:0]         vga_x,
    output logic [VGA_Y_W-1:0]         vga_y,
    output logic [VGA_COLOUR_W-1:0]    vga_colour,
    output logic                       vga_plot,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic [15:0]                drop_count
);

    localparam int          ID_W     = $clog2(NUM_REQ);
    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            busy_q, busy_d;
    logic            plot_q, plot_d;
    pixel_t          pix_q, pix_d;
    logic [15:0]     drop_q, drop_d;

    logic            pick_any;
    logic [ID_W-1:0] pick_idx;
    logic            sel_valid, sel_lock;
    pixel_t          sel_pix;
    logic            xfer, on_screen;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req (req.req_valid),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Select the current owner's request fields.
    always_comb begin
        sel_valid = 1'b0;
        sel_lock  = 1'b0;
        sel_pix   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == ID_W'(i)) begin
                sel_valid      = req.req_valid[i];
                sel_lock       = req.req_lock[i];
                sel_pix.x      = req.req_x[VGA_X_W*i +: VGA_X_W];
                sel_pix.y      = req.req_y[VGA_Y_W*i +: VGA_Y_W];
                sel_pix.colour = req.req_colour[VGA_COLOUR_W*i +: VGA_COLOUR_W];
            end
        end
    end

    // Ready is decoded from the grant registers only, never from valid.
    always_comb begin
        req.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req.req_ready[i] = busy_q && (grant_q == ID_W'(i));
        end
    end

    assign xfer      = busy_q && sel_valid;
    assign on_screen = (int'(sel_pix.x) < X_MAX) && (int'(sel_pix.y) < Y_MAX);

    // Next owner: a locked owner keeps the port, otherwise round-robin from ptr.
    always_comb begin
        grant_d = grant_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        if (!(busy_q && sel_lock)) begin
            if (pick_any) begin
                grant_d = pick_idx;
                busy_d  = 1'b1;
                ptr_d   = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + ID_W'(1);
            end else begin
                busy_d = 1'b0;
            end
        end
    end

    // Output pixel register and saturating count of clipped pixels.
    always_comb begin
        pix_d  = pix_q;
        plot_d = 1'b0;
        drop_d = drop_q;
        if (xfer) begin
            pix_d = sel_pix;
            if (on_screen) begin
                plot_d = 1'b1;
            end else if (drop_q != DROP_MAX) begin
                drop_d = drop_q + 16'd1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rstn) begin
            grant_q <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            plot_q  <= 1'b0;
            pix_q   <= '0;
            drop_q  <= '0;
        end else begin
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            plot_q  <= plot_d;
            pix_q   <= pix_d;
            drop_q  <= drop_d;
        end
    end

    assign vga_x      = pix_q.x;
    assign vga_y      = pix_q.y;
    assign vga_colour = pix_q.colour;
    assign vga_plot   = plot_q;
    assign grant_id   = grant_q;
    assign busy       = busy_q;
    assign drop_count = drop_q;

endmodule
